// File: rtl/mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg : range helpers shared by the modulo counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int MAX_WIDTH = 32;

  // MAX is returned at 33 bits so that a full 32-bit range is representable.
  function automatic logic [32:0] max_count(input int width, input longint modulus);
    if (modulus == 0) begin
      return (33'd1 << width) - 33'd1;
    end
    return 33'(modulus - 1);
  endfunction

  function automatic bit modulus_ok(input int width, input longint modulus);
    if (width < 1 || width > MAX_WIDTH) begin
      return 1'b0;
    end
    return (modulus == 0) || (modulus >= 2 && modulus <= (longint'(1) << width));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_if.sv
// ---------------------------------------------------------------------------
// mod_counter_if : control and status bundle of one counter unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mod_counter_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             wrapped;

  modport master (
    output enable, up, load, load_value,
    input  Q, tc, wrapped
  );

  modport slave (
    input  enable, up, load, load_value,
    output Q, tc, wrapped
  );
endinterface

`default_nettype wire

// File: rtl/mod_counter_next.sv
// ---------------------------------------------------------------------------
// mod_counter_next : combinational next-count and limit-event logic
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_counter_next #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             limit_o
);

  logic [WIDTH:0] w_q_ext;
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;
  logic           w_at_max;
  logic           w_at_zero;

  assign w_q_ext   = {1'b0, q_i};
  assign w_inc     = w_q_ext + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec     = w_q_ext - {{WIDTH{1'b0}}, 1'b1};
  assign w_at_max  = (q_i == max_i);
  assign w_at_zero = (q_i == '0);

  always_comb begin
    next_q_o = q_i;
    limit_o  = 1'b0;
    if (up_i) begin
      limit_o = w_at_max;
      if (!w_at_max) begin
        next_q_o = w_inc[WIDTH-1:0];
      end else if (!SATURATE) begin
        next_q_o = '0;
      end
    end else begin
      limit_o = w_at_zero;
      if (!w_at_zero) begin
        next_q_o = w_dec[WIDTH-1:0];
      end else if (!SATURATE) begin
        next_q_o = max_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter : WIDTH-bit up/down modulo counter with load, tc and sticky flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 16,
  parameter longint MODULUS  = 0,
  parameter bit     SATURATE = 1'b0
) (
  input  logic            clock,
  input  logic            clear,
  mod_counter_if.slave    bus
);

  localparam bit          C_CFG_OK   = modulus_ok(WIDTH, MODULUS);
  localparam logic [32:0] C_MAX_FULL = max_count(WIDTH, MODULUS);
  localparam logic [WIDTH-1:0] C_MAX = C_MAX_FULL[WIDTH-1:0];

  generate
    if (!C_CFG_OK) begin : g_bad_cfg
      $error("mod_counter: WIDTH must be 1..32 and MODULUS 0 or 2..2^WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH-1:0] w_next_q;
  logic             w_limit;
  logic [WIDTH-1:0] w_load_q;

  mod_counter_next #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .q_i      (q_q),
    .up_i     (bus.up),
    .max_i    (C_MAX),
    .next_q_o (w_next_q),
    .limit_o  (w_limit)
  );

  // Loaded values above MAX are clamped so Q never leaves 0..MAX.
  assign w_load_q = ({1'b0, bus.load_value} > {1'b0, C_MAX}) ? C_MAX : bus.load_value;

  always_comb begin
    q_d       = q_q;
    tc_d      = 1'b0;
    wrapped_d = wrapped_q;
    if (bus.load) begin
      q_d       = w_load_q;
      wrapped_d = 1'b0;
    end else if (bus.enable) begin
      q_d       = w_next_q;
      tc_d      = w_limit;
      wrapped_d = wrapped_q | w_limit;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      q_q       <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.tc      = tc_q;
  assign bus.wrapped = wrapped_q;

endmodule

`default_nettype wire

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous modulo counter: generalises the fixed 16-bit enable-gated up counter into a WIDTH-bit up/down counter with programmable modulus, parallel load, wrap or saturate mode, a registered terminal-count pulse and a sticky event flag. It is the counting primitive for timers, clock dividers and address sequencers in later labs. Units can cascade by feeding one unit's tc into the next unit's enable.

## Interface
Parameters:
- WIDTH, 16, counter width in bits (1..32)
- MODULUS, 0, count range 0..MODULUS-1; 0 means full range 2^WIDTH; otherwise 2..2^WIDTH
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends

Ports:
- clock  in  1  rising-edge clock; the only clock
- clear  in  1  synchronous, active-high reset
- enable  in  1  count one step this cycle
- up  in  1  1 = increment, 0 = decrement; sampled only when enable=1
- load  in  1  parallel load this cycle
- load_value  in  WIDTH  value for load
- Q  out  WIDTH  count, registered
- tc  out  1  terminal-count/limit pulse, registered
- wrapped  out  1  sticky flag: a limit event occurred since the last clear or load

## Operation
- Reset values: clear=1 at a rising edge sets Q=0, tc=0, wrapped=0.
- Priority at each edge: clear > load > enable > hold.
- Load: Q <= load_value, or Q <= MAX if load_value > MAX, where MAX = MODULUS-1 (or 2^WIDTH-1 when MODULUS=0). A load also sets tc=0 and wrapped=0.
- Count, up=1:
  - Q<MAX: Q <= Q+1.
  - Q==MAX, wrap mode: Q <= 0.
  - Q==MAX, saturate mode: Q holds.
- Count, up=0:
  - Q>0: Q <= Q-1.
  - Q==0, wrap mode: Q <= MAX.
  - Q==0, saturate mode: Q holds.
- Limit event: an enabled step taken at Q==MAX with up=1, or at Q==0 with up=0.
  - tc=1 for the cycle after every limit event; otherwise tc=0.
  - wrapped is set by a limit event and stays set until clear or load.
- No step is taken when enable=0. tc=0 in that cycle; wrapped holds.
- The up input is ignored when enable=0.
- Arithmetic is done at WIDTH+1 bits internally. Q never leaves 0..MAX, including after a load.

## Timing
- Latency: Q, tc and wrapped change only on the rising edge of clock. All outputs come directly from flops; there is no combinational input-to-output path.
- Q reflects an enabled step one edge after enable is sampled high.
- tc is coincident with the new Q value. Example: on a wrap-up, the cycle with Q=0 also has tc=1.
- Back-to-back enables step on every edge. When held at a limit in saturate mode, tc stays 1 on every edge that enable remains high.
- Simultaneous load and enable: the load wins, no step occurs, tc=0.
- clear raised mid-count returns the counter to the reset state at the next edge, whatever the other inputs are. clear held high keeps it there.
- Direction can reverse on any cycle with no penalty cycle.

## Structure
- Shared package counter_pkg holds:
  - the function max_count(WIDTH, MODULUS) that computes MAX;
  - localparam checks on the legal MODULUS range, which fail elaboration if MODULUS is out of range.
- One combinational sub-module, mod_counter_next, takes (Q, up, MAX, SATURATE) and returns next_q and limit.
- The top level holds the priority mux plus the Q, tc and wrapped registers.

## Test plan
- Reset: set clear=1 with enable=1, up=1, load=1 for 2 edges -> Q=0, tc=0, wrapped=0 after each edge.
- Decade wrap-up (WIDTH=4, MODULUS=10): from 0, enable up for 10 edges -> Q goes 1..9 then 0. tc=1 only in the Q=0 cycle, wrapped=1 from then on.
- Wrap-down (WIDTH=4, MODULUS=10): from 0, one down step -> Q=9, tc=1. One more down step -> Q=8, tc=0.
- Saturate (WIDTH=4, MODULUS=0, SATURATE=1):
  - load 14, then 3 up steps -> Q goes 15, 15, 15 with tc=0, 1, 1;
  - then 1 down step -> Q=14, tc=0, wrapped=1.
- Load rules (WIDTH=4, MODULUS=10):
  - load_value=12 -> Q=9, wrapped=0;
  - load=1 with enable=1 and load_value=3 -> Q=3, not 4.
- Enable gating and full range (WIDTH=16): hold enable=0 for 5 edges at Q=0x1234 -> Q unchanged.
  - Then run 65536 up steps from 0 -> the check Q==step index mod 65536 holds every cycle, and tc=1 exactly once, at Q=0.
